// File: rtl/red_pitaya_dsp_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_router_pkg
//  Brief    : Shared register map, region decode type and elaboration helpers
//             for the DSP routing / DAC summing fabric.
//  Revision : 1.0 - initial release
// ============================================================================
package dsp_router_pkg;

  // Register offsets (byte addresses, module-local)
  localparam logic [15:0] SEL_BASE    = 16'h0000;
  localparam logic [15:0] MASK_BASE   = 16'h0100;
  localparam logic [15:0] COMMIT      = 16'h0200;
  localparam logic [15:0] SATFLAG     = 16'h0204;
  localparam logic [15:0] SATCNT_BASE = 16'h0208;

  // Which register bank a bus offset falls into
  typedef enum logic [2:0] {
    REG_NONE    = 3'd0,
    REG_SEL     = 3'd1,
    REG_MASK    = 3'd2,
    REG_COMMIT  = 3'd3,
    REG_SATFLAG = 3'd4,
    REG_SATCNT  = 3'd5
  } reg_region_e;

  // Ceiling log2, valid for n >= 1
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // The first code past the last source is the "drive zero" selection
  function automatic int none_code(input int n_src);
    return n_src;
  endfunction

  // Number of nodes at a given adder-tree level (level 0 = operands)
  function automatic int tree_nodes(input int n_in, input int lvl);
    return (n_in + (1 << lvl) - 1) >> lvl;
  endfunction

  // Start index of a level inside the flattened node array
  function automatic int tree_offset(input int n_in, input int lvl);
    int off;
    off = 0;
    for (int l = 0; l < lvl; l++) off = off + tree_nodes(n_in, l);
    return off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/red_pitaya_dsp_router_adder_tree.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_adder_tree
//  Brief    : Masked, pipelined pairwise adder tree followed by a registered
//             saturator. Latency from i_din to o_dout is clog2(N_IN)+1.
//  Revision : 1.0 - initial release
// ============================================================================
module dsp_adder_tree
  import dsp_router_pkg::*;
#(
  parameter int DW   = 14,
  parameter int N_IN = 10
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [N_IN*DW-1:0] i_din,
  input  logic [N_IN-1:0]    i_mask,
  output logic [DW-1:0]      o_dout,
  output logic               o_sat
);

  localparam int T     = clog2(N_IN);
  localparam int AW    = DW + T;
  localparam int TOTAL = tree_offset(N_IN, T + 1);

  localparam logic signed [AW-1:0] C_MAX = AW'((1 << (DW - 1)) - 1);
  localparam logic signed [AW-1:0] C_MIN = ~C_MAX;

  // All tree levels flattened; level l occupies tree_offset(l) .. +tree_nodes(l)-1
  logic signed [AW-1:0] w_all [TOTAL];
  logic signed [AW-1:0] w_fin;
  logic [DW-1:0]        r_dout;
  logic                 r_sat;

  for (genvar l = 0; l <= T; l++) begin : g_lvl
    localparam int NN  = tree_nodes(N_IN, l);
    localparam int OFF = tree_offset(N_IN, l);
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < NN; i++) begin : g_op
        // Masked operand contributes zero; otherwise sign-extend to tree width
        assign w_all[OFF+i] = i_mask[i] ?
                              {{(AW - DW){i_din[i*DW+DW-1]}}, i_din[i*DW +: DW]} : '0;
      end
    end else begin : g_stage
      localparam int NP   = tree_nodes(N_IN, l - 1);
      localparam int POFF = tree_offset(N_IN, l - 1);
      for (genvar i = 0; i < NN; i++) begin : g_node
        logic signed [AW-1:0] r_sum;
        if (2 * i + 1 < NP) begin : g_add
          // Pairwise sum of two nodes from the previous level
          always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) r_sum <= '0;
            else         r_sum <= w_all[POFF+2*i] + w_all[POFF+2*i+1];
          end
        end else begin : g_pass
          // Odd leftover node is delayed so all paths keep equal latency
          always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) r_sum <= '0;
            else         r_sum <= w_all[POFF+2*i];
          end
        end
        assign w_all[OFF+i] = r_sum;
      end
    end
  end

  assign w_fin = w_all[tree_offset(N_IN, T)];

  // Clamp the full-width sum into the DAC range and flag when clamping happened
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_dout <= '0;
      r_sat  <= 1'b0;
    end else if (w_fin > C_MAX) begin
      r_dout <= C_MAX[DW-1:0];
      r_sat  <= 1'b1;
    end else if (w_fin < C_MIN) begin
      r_dout <= C_MIN[DW-1:0];
      r_sat  <= 1'b1;
    end else begin
      r_dout <= w_fin[DW-1:0];
      r_sat  <= 1'b0;
    end
  end

  assign o_dout = r_dout;
  assign o_sat  = r_sat;

endmodule
`default_nettype wire

// File: rtl/red_pitaya_dsp_router.sv
`default_nettype none
// ============================================================================
//  Module   : red_pitaya_dsp_router
//  Brief    : Source-to-destination routing matrix and masked DAC summing with
//             double-buffered configuration, atomic commit, sticky saturation
//             flags and per-DAC saturation counters behind a simple bus.
//  Revision : 1.0 - initial release
// ============================================================================
module red_pitaya_dsp_router
  import dsp_router_pkg::*;
#(
  parameter int DW       = 14,
  parameter int N_SRC    = 14,
  parameter int N_DST    = 12,
  parameter int N_DIRECT = 10,
  parameter int N_DAC    = 2,
  parameter int SELW     = 4
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [N_SRC*DW-1:0]    src_i,
  input  logic [N_DIRECT*DW-1:0] direct_i,
  output logic [N_DST*DW-1:0]    dst_o,
  output logic [N_DAC*DW-1:0]    dac_o,
  output logic [N_DAC-1:0]       sat_o,
  input  logic [15:0]            sys_addr,
  input  logic [31:0]            sys_wdata,
  input  logic                   sys_wen,
  input  logic                   sys_ren,
  output logic [31:0]            sys_rdata,
  output logic                   sys_ack,
  output logic                   sys_err
);

  localparam logic [SELW-1:0] C_NONE = SELW'(none_code(N_SRC));

  // Configuration banks: software edits shadow, datapath uses active
  logic [SELW-1:0]  r_shd_sel  [N_DST];
  logic [SELW-1:0]  r_act_sel  [N_DST];
  logic [N_DAC-1:0] r_shd_mask [N_DIRECT];
  logic [N_DAC-1:0] r_act_mask [N_DIRECT];
  logic             r_commit_pend;

  // Status
  logic [N_DAC-1:0] r_satflag;
  logic [15:0]      r_satcnt [N_DAC];

  // Bus response
  logic             r_ack;
  logic             r_err;
  logic [31:0]      r_rdata;

  // Datapath
  logic [N_DST*DW-1:0] r_dst;
  logic [N_DST*DW-1:0] w_dst;
  logic [N_DAC-1:0]    w_sat;

  // Decode
  logic             w_req;
  logic [31:0]      w_idx;
  logic [7:0]       w_cnt_off;
  logic [31:0]      w_cnt_idx;
  reg_region_e      w_region;
  logic [31:0]      w_rd;
  logic             w_wr_sel;
  logic             w_wr_mask;
  logic             w_wr_commit;
  logic             w_wr_cnt;
  logic [N_DAC-1:0] w_flag_clr;
  logic             w_unused;

  assign w_req     = sys_wen | sys_ren;
  assign w_idx     = {26'd0, sys_addr[7:2]};
  assign w_cnt_off = sys_addr[7:0] - SATCNT_BASE[7:0];
  assign w_cnt_idx = {26'd0, w_cnt_off[7:2]};
  assign w_unused  = ^{sys_wdata, w_cnt_off[1:0]};

  // Map the bus offset onto a register bank; anything else is an error
  always_comb begin
    w_region = REG_NONE;
    if (sys_addr[1:0] == 2'b00) begin
      if (sys_addr[15:8] == SEL_BASE[15:8] && w_idx < 32'(N_DST))
        w_region = REG_SEL;
      else if (sys_addr[15:8] == MASK_BASE[15:8] && w_idx < 32'(N_DIRECT))
        w_region = REG_MASK;
      else if (sys_addr == COMMIT)
        w_region = REG_COMMIT;
      else if (sys_addr == SATFLAG)
        w_region = REG_SATFLAG;
      else if (sys_addr[15:8] == SATCNT_BASE[15:8] &&
               sys_addr[7:0] >= SATCNT_BASE[7:0] && w_cnt_idx < 32'(N_DAC))
        w_region = REG_SATCNT;
    end
  end

  assign w_wr_sel    = sys_wen && (w_region == REG_SEL);
  assign w_wr_mask   = sys_wen && (w_region == REG_MASK);
  assign w_wr_commit = sys_wen && (w_region == REG_COMMIT) && sys_wdata[0];
  assign w_wr_cnt    = sys_wen && (w_region == REG_SATCNT);
  assign w_flag_clr  = (sys_wen && (w_region == REG_SATFLAG)) ? sys_wdata[N_DAC-1:0] : '0;

  // Read data mux; page reads return the shadow (editable) values
  always_comb begin
    w_rd = '0;
    case (w_region)
      REG_SEL: begin
        for (int d = 0; d < N_DST; d++)
          if (w_idx == 32'(d)) w_rd[SELW-1:0] = r_shd_sel[d];
      end
      REG_MASK: begin
        for (int k = 0; k < N_DIRECT; k++)
          if (w_idx == 32'(k)) w_rd[N_DAC-1:0] = r_shd_mask[k];
      end
      REG_COMMIT:  w_rd[0] = r_commit_pend;
      REG_SATFLAG: w_rd[N_DAC-1:0] = r_satflag;
      REG_SATCNT: begin
        for (int c = 0; c < N_DAC; c++)
          if (w_cnt_idx == 32'(c)) w_rd[15:0] = r_satcnt[c];
      end
      default: w_rd = '0;
    endcase
  end

  // Single-cycle acknowledge with registered read data and error flag
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_req;
      r_err   <= w_req && (w_region == REG_NONE);
      r_rdata <= (sys_ren && (w_region != REG_NONE)) ? w_rd : '0;
    end
  end

  // Shadow edits, commit request and the one-cycle shadow-to-active copy
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int d = 0; d < N_DST; d++) begin
        r_shd_sel[d] <= C_NONE;
        r_act_sel[d] <= C_NONE;
      end
      for (int k = 0; k < N_DIRECT; k++) begin
        r_shd_mask[k] <= '0;
        r_act_mask[k] <= '0;
      end
      r_commit_pend <= 1'b0;
    end else begin
      for (int d = 0; d < N_DST; d++)
        if (w_wr_sel && w_idx == 32'(d)) r_shd_sel[d] <= sys_wdata[SELW-1:0];
      for (int k = 0; k < N_DIRECT; k++)
        if (w_wr_mask && w_idx == 32'(k)) r_shd_mask[k] <= sys_wdata[N_DAC-1:0];
      // A commit arriving while one is pending is absorbed into it
      if (r_commit_pend) begin
        r_act_sel     <= r_shd_sel;
        r_act_mask    <= r_shd_mask;
        r_commit_pend <= 1'b0;
      end else if (w_wr_commit) begin
        r_commit_pend <= 1'b1;
      end
    end
  end

  // Per-destination source selection; out-of-range codes give zero
  always_comb begin
    w_dst = '0;
    for (int d = 0; d < N_DST; d++)
      for (int s = 0; s < N_SRC; s++)
        if (r_act_sel[d] == SELW'(s)) w_dst[d*DW +: DW] = src_i[s*DW +: DW];
  end

  // Register routed destinations
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_dst <= '0;
    else         r_dst <= w_dst;
  end

  assign dst_o = r_dst;

  for (genvar c = 0; c < N_DAC; c++) begin : g_dac
    logic [N_DIRECT-1:0] w_col;
    for (genvar k = 0; k < N_DIRECT; k++) begin : g_col
      assign w_col[k] = r_act_mask[k][c];
    end
    dsp_adder_tree #(
      .DW   (DW),
      .N_IN (N_DIRECT)
    ) u_tree (
      .i_clk  (clk_i),
      .i_rstn (rstn_i),
      .i_din  (direct_i),
      .i_mask (w_col),
      .o_dout (dac_o[c*DW +: DW]),
      .o_sat  (w_sat[c])
    );
  end

  assign sat_o = w_sat;

  // Sticky flags and saturating counters; a saturation event beats a clear
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_satflag <= '0;
      for (int c = 0; c < N_DAC; c++) r_satcnt[c] <= '0;
    end else begin
      r_satflag <= (r_satflag & ~w_flag_clr) | w_sat;
      for (int c = 0; c < N_DAC; c++) begin
        if (w_sat[c]) begin
          if (w_wr_cnt && w_cnt_idx == 32'(c)) r_satcnt[c] <= 16'd1;
          else if (r_satcnt[c] != 16'hFFFF)    r_satcnt[c] <= r_satcnt[c] + 16'd1;
        end else if (w_wr_cnt && w_cnt_idx == 32'(c)) begin
          r_satcnt[c] <= '0;
        end
      end
    end
  end

  assign sys_ack   = r_ack;
  assign sys_err   = r_err;
  assign sys_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_dsp_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_red_pitaya_dsp_router
//  Brief    : Directed scoreboard bench for the DSP router: bus responses are
//             matched on sys_ack, datapath expectations on their due cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_red_pitaya_dsp_router;

  localparam int DW       = 14;
  localparam int N_SRC    = 14;
  localparam int N_DST    = 12;
  localparam int N_DIRECT = 10;
  localparam int N_DAC    = 2;
  localparam int T        = 4;

  localparam int K_DST  = 0;
  localparam int K_DAC  = 1;
  localparam int K_SAT  = 2;
  localparam int K_ZERO = 3;
  localparam int K_BUSF = 4;
  localparam int K_BUSR = 5;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic [N_SRC*DW-1:0]    src_i = '0;
  logic [N_DIRECT*DW-1:0] direct_i = '0;
  logic [N_DST*DW-1:0]    dst_o;
  logic [N_DAC*DW-1:0]    dac_o;
  logic [N_DAC-1:0]       sat_o;
  logic [15:0]            sys_addr = '0;
  logic [31:0]            sys_wdata = '0;
  logic                   sys_wen = 1'b0;
  logic                   sys_ren = 1'b0;
  logic [31:0]            sys_rdata;
  logic                   sys_ack;
  logic                   sys_err;

  red_pitaya_dsp_router dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .src_i     (src_i),
    .direct_i  (direct_i),
    .dst_o     (dst_o),
    .dac_o     (dac_o),
    .sat_o     (sat_o),
    .sys_addr  (sys_addr),
    .sys_wdata (sys_wdata),
    .sys_wen   (sys_wen),
    .sys_ren   (sys_ren),
    .sys_rdata (sys_rdata),
    .sys_ack   (sys_ack),
    .sys_err   (sys_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } bus_exp_t;

  typedef struct {
    int          due;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } dp_exp_t;

  bus_exp_t bus_q[$];
  dp_exp_t  dp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic int src_val(input int s);
    return s * 37 - 200;
  endfunction

  function automatic logic [31:0] actual(input int kind, input int idx);
    logic signed [DW-1:0] v;
    case (kind)
      K_DST:   begin v = dst_o[idx*DW +: DW]; return 32'(v); end
      K_DAC:   begin v = dac_o[idx*DW +: DW]; return 32'(v); end
      K_SAT:   return {31'd0, sat_o[idx]};
      K_ZERO:  return {31'd0, |{dst_o, dac_o, sat_o}};
      K_BUSF:  return {30'd0, sys_ack, sys_err};
      default: return sys_rdata;
    endcase
  endfunction

  // Monitor: match bus responses on ack, datapath entries on their due cycle
  always @(negedge clk) begin
    bus_exp_t be;
    logic [31:0] a;
    if (sys_ack) begin
      checks++;
      if (bus_q.size() == 0) begin
        errors++;
        $display("FAIL bus_unexpected_ack: got ack at cycle %0d, required none", cyc);
      end else begin
        be = bus_q.pop_front();
        if (be.cyc != cyc || sys_rdata != be.rdata || sys_err != be.err) begin
          errors++;
          $display("FAIL %s: got cyc %0d rdata %h err %b, required cyc %0d rdata %h err %b",
                   be.name, cyc, sys_rdata, sys_err, be.cyc, be.rdata, be.err);
        end
      end
    end else if (bus_q.size() > 0 && bus_q[0].cyc < cyc) begin
      be = bus_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got no ack by cycle %0d, required ack at cycle %0d", be.name, cyc, be.cyc);
    end
    for (int i = dp_q.size() - 1; i >= 0; i--) begin
      if (dp_q[i].due == cyc) begin
        a = actual(dp_q[i].kind, dp_q[i].idx);
        checks++;
        if (a !== dp_q[i].exp) begin
          errors++;
          $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)",
                   dp_q[i].name, $signed(a), a, $signed(dp_q[i].exp), dp_q[i].exp);
        end
        dp_q.delete(i);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_dp(input int delay, input int kind, input int idx,
                           input int exp, input string nm);
    dp_q.push_back('{cyc + delay, kind, idx, 32'(exp), nm});
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d,
                        input logic e, input string nm);
    sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
    bus_q.push_back('{cyc + 1, 32'd0, e, nm});
    @(posedge clk); #1;
    sys_wen = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, input logic [31:0] d,
                        input logic e, input string nm);
    sys_addr = a; sys_ren = 1'b1;
    bus_q.push_back('{cyc + 1, d, e, nm});
    @(posedge clk); #1;
    sys_ren = 1'b0;
  endtask

  task automatic set_direct(input int k, input int v);
    direct_i[k*DW +: DW] = DW'(v);
  endtask

  task automatic all_direct(input int v);
    for (int k = 0; k < N_DIRECT; k++) set_direct(k, v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test by time %0t, required earlier finish", $time);
    $fatal(1);
  end

  initial begin
    // Reset state
    idle(3);
    expect_dp(0, K_ZERO, 0, 0, "reset_outputs");
    expect_dp(0, K_BUSF, 0, 0, "reset_ack_err");
    expect_dp(0, K_BUSR, 0, 0, "reset_rdata");
    idle(1);
    rstn = 1'b1;
    idle(2);
    for (int s = 0; s < N_SRC; s++) src_i[s*DW +: DW] = DW'(src_val(s));

    // Routing: shadow edit has no effect until commit, then switches atomically
    bus_rd(16'h000C, 32'd14, 1'b0, "sel3_reset_none");
    bus_rd(16'h0104, 32'd0, 1'b0, "mask1_reset");
    bus_wr(16'h000C, 32'd5, 1'b0, "wr_sel3");
    bus_rd(16'h000C, 32'd5, 1'b0, "sel3_shadow_readback");
    idle(3);
    expect_dp(0, K_DST, 3, 0, "dst3_before_commit");
    idle(1);
    bus_wr(16'h0200, 32'd1, 1'b0, "commit_route");
    expect_dp(1, K_DST, 3, 0, "dst3_old_config");
    expect_dp(2, K_DST, 3, src_val(5), "dst3_after_commit");
    expect_dp(2, K_DST, 0, 0, "dst0_unrouted");
    bus_rd(16'h0200, 32'd1, 1'b0, "commit_pending");
    idle(1);
    bus_rd(16'h0200, 32'd0, 1'b0, "commit_done");

    // Select code boundaries and a double commit
    bus_wr(16'h0010, 32'd2, 1'b0, "wr_sel4_src2");
    bus_wr(16'h0200, 32'd1, 1'b0, "commit_sel4");
    idle(3);
    expect_dp(0, K_DST, 4, src_val(2), "dst4_src2");
    bus_wr(16'h0010, 32'd15, 1'b0, "wr_sel4_none");
    bus_wr(16'h0014, 32'd13, 1'b0, "wr_sel5_last");
    bus_wr(16'h0200, 32'd1, 1'b0, "commit_a");
    bus_wr(16'h0200, 32'd1, 1'b0, "commit_b_while_pending");
    idle(3);
    expect_dp(0, K_DST, 4, 0, "dst4_code15_zero");
    expect_dp(0, K_DST, 5, src_val(13), "dst5_src13");
    bus_rd(16'h0200, 32'd0, 1'b0, "double_commit_cleared");

    // Summing: masks route directs 0,1 to DAC0 and direct 2 to both DACs
    set_direct(0, 1000);
    set_direct(1, -300);
    set_direct(2, 50);
    set_direct(3, 77);
    bus_wr(16'h0100, 32'd1, 1'b0, "wr_mask0");
    bus_wr(16'h0104, 32'd1, 1'b0, "wr_mask1");
    bus_wr(16'h0108, 32'd3, 1'b0, "wr_mask2");
    bus_wr(16'h0200, 32'd1, 1'b0, "commit_masks");
    idle(10);
    expect_dp(0, K_DAC, 0, 750, "dac0_sum");
    expect_dp(0, K_DAC, 1, 50, "dac1_sum");
    expect_dp(0, K_SAT, 0, 0, "sat0_no_clamp");
    idle(1);
    set_direct(0, 2000);
    expect_dp(T, K_DAC, 0, 750, "dac0_latency_T_old");
    expect_dp(T + 1, K_DAC, 0, 1750, "dac0_latency_T1_new");
    idle(8);

    // Positive saturation on DAC0 with every direct enabled
    for (int k = 0; k < N_DIRECT; k++)
      bus_wr(16'(16'h0100 + 4 * k), 32'd1, 1'b0, "wr_mask_all");
    bus_wr(16'h0200, 32'd1, 1'b0, "commit_all");
    all_direct(8191);
    idle(10);
    expect_dp(0, K_DAC, 0, 8191, "dac0_pos_clamp");
    expect_dp(0, K_SAT, 0, 1, "sat0_pos");
    expect_dp(0, K_DAC, 1, 0, "dac1_masked_off");
    expect_dp(0, K_SAT, 1, 0, "sat1_idle");
    bus_rd(16'h0204, 32'd1, 1'b0, "flag_set");
    bus_wr(16'h0208, 32'd0, 1'b0, "cnt0_clear_race");
    bus_rd(16'h0208, 32'd1, 1'b0, "cnt0_after_clear_race");
    idle(3);
    bus_rd(16'h0208, 32'd5, 1'b0, "cnt0_counting");
    bus_wr(16'h0204, 32'd1, 1'b0, "flag_w1c_race");
    bus_rd(16'h0204, 32'd1, 1'b0, "flag_kept_by_race");

    // Negative clamp, then a single full-scale negative that fits
    all_direct(-8192);
    idle(8);
    expect_dp(0, K_DAC, 0, -8192, "dac0_neg_clamp");
    expect_dp(0, K_SAT, 0, 1, "sat0_neg");
    all_direct(0);
    set_direct(0, -8192);
    idle(8);
    expect_dp(0, K_DAC, 0, -8192, "dac0_single_min");
    expect_dp(0, K_SAT, 0, 0, "sat0_single_min");
    bus_rd(16'h0204, 32'd1, 1'b0, "flag_still_sticky");
    bus_wr(16'h0204, 32'd1, 1'b0, "flag_w1c");
    bus_rd(16'h0204, 32'd0, 1'b0, "flag_cleared");

    // Counter saturates at 0xFFFF
    all_direct(8191);
    idle(6);
    bus_wr(16'h0208, 32'd0, 1'b0, "cnt0_restart");
    idle(65540);
    bus_rd(16'h0208, 32'h0000FFFF, 1'b0, "cnt0_cap");
    bus_rd(16'h020C, 32'd0, 1'b0, "cnt1_zero");

    // Unmapped offsets
    bus_rd(16'h03FC, 32'd0, 1'b1, "rd_unmapped_3fc");
    bus_wr(16'h03FC, 32'hFFFFFFFF, 1'b1, "wr_unmapped_3fc");
    bus_rd(16'h0030, 32'd0, 1'b1, "rd_sel_past_last");
    bus_rd(16'h0210, 32'd0, 1'b1, "rd_cnt_past_last");

    // Asynchronous reset in the middle of a cycle while streaming
    @(posedge clk); #3;
    rstn = 1'b0;
    expect_dp(0, K_ZERO, 0, 0, "midreset_outputs");
    expect_dp(0, K_BUSF, 0, 0, "midreset_ack_err");
    idle(2);
    rstn = 1'b1;
    idle(1);
    bus_rd(16'h000C, 32'd14, 1'b0, "sel3_none_after_reset");
    bus_rd(16'h0100, 32'd0, 1'b0, "mask0_after_reset");
    bus_rd(16'h0204, 32'd0, 1'b0, "flags_after_reset");
    expect_dp(0, K_DST, 3, 0, "dst3_after_reset");
    expect_dp(0, K_DAC, 0, 0, "dac0_after_reset");
    idle(10);

    foreach (bus_q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: got no response, required ack at cycle %0d", bus_q[i].name, bus_q[i].cyc);
    end
    foreach (dp_q[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: got no sample, required check at cycle %0d", dp_q[i].name, dp_q[i].due);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
